// File: rtl/rr_decoder_arbiter4.sv
// rr_decoder_arbiter4: four-requester round-robin arbiter driving a 2-to-4
// decoder. The owner keeps the grant until it drops its request; the grant,
// the select index and the handover pulse are all registered.
// Optional feature macro: RR_ARB_HOLD_LIMIT_EN -- when defined, an owner that
// has held the grant for MAX_HOLD cycles is revoked as soon as another agent
// is waiting. When undefined, the hold counter does not exist.
module rr_decoder_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       handover
);

  // Reject illegal configurations at elaboration time.
  if ((MAX_HOLD < 32'd2) || (MAX_HOLD > 32'd255) ||
      ((CNT_W < 32'd9) && ((32'd1 << CNT_W) <= MAX_HOLD))) begin : g_bad_params
    $error("rr_decoder_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // 2-to-4 decoder for the select lines.
  function automatic logic [3:0] decode2to4(input logic [1:0] idx);
    logic [3:0] onehot;
    case (idx)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Round-robin search starting at 'start'; returns {found, index}.
  // Scanning from the farthest offset back to offset 0 lets the nearest
  // requester overwrite the result, so the first hit in search order wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] cand;
    logic [1:0] offs;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      offs = i[1:0];
      cand = start + offs;
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       handover_q, handover_d;
  logic [3:0] gnt_q, gnt_d;

  logic [2:0] pick_idle_s;   // winner when arbitrating from IDLE
  logic [1:0] ptr_next_s;    // pointer just past the current owner
  logic [2:0] pick_next_s;   // winner when the current owner gives up
  logic       release_s;     // owner dropped its request
  logic       owner_off_s;   // owner loses the grant at this edge

  assign pick_idle_s = rr_pick(req, ptr_q);
  assign ptr_next_s  = idx_q + 2'd1;
  assign pick_next_s = rr_pick(req, ptr_next_s);
  assign release_s   = ~req[idx_q];

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD - 32'd1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             others_req_s;  // some agent other than the owner is waiting
  logic             force_s;       // hold limit reached with a waiter present

  assign others_req_s = |(req & ~decode2to4(idx_q));
  assign force_s      = (hold_q == HOLD_SAT) && others_req_s;
  assign owner_off_s  = release_s | force_s;
`else
  assign owner_off_s  = release_s;
`endif

  // State register: all arbiter state plus the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      idx_q      <= 2'd0;
      handover_q <= 1'b0;
      gnt_q      <= 4'b0000;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      handover_q <= handover_d;
      gnt_q      <= gnt_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q     <= hold_d;
`endif
    end
  end

  // Next-state logic: grant from idle, hold, release or forced handover.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    handover_d = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_idle_s[2]) begin
          state_d    = ST_GRANT;
          idx_d      = pick_idle_s[1:0];
          handover_d = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d     = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (owner_off_s) begin
          // The leaving owner moves to lowest priority.
          ptr_d = ptr_next_s;
          if (pick_next_s[2]) begin
            state_d    = ST_GRANT;
            idx_d      = pick_next_s[1:0];
            handover_d = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_d     = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GRANT;
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            hold_d = hold_q;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = 2'd0;
        idx_d   = 2'd0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_d  = '0;
`endif
      end
    endcase
  end

  // Output logic: decoded grant for the state being entered.
  always_comb begin
    gnt_d = 4'b0000;
    if (state_d == ST_GRANT) begin
      gnt_d = decode2to4(idx_d);
    end else begin
      gnt_d = 4'b0000;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign handover  = handover_q;

endmodule

// File: tb/tb_rr_decoder_arbiter4.sv
// Testbench for rr_decoder_arbiter4: directed scenarios followed by random
// request traffic, checked against a queue of expected outputs produced by an
// integer-level round-robin model.
module tb_rr_decoder_arbiter4;

  localparam int MAX_HOLD = 4;
`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       handover;

  rr_decoder_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .handover(handover)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       ho;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state (plain integers).
  int m_owner = -1;   // -1 means nobody owns the resource
  int m_last  = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_ho    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
  endtask

  function automatic int find_winner(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_ho = 0;
  endtask

  // Advance the model by one clock edge with request vector r.
  task automatic model_step(input logic [3:0] r);
    int  w;
    bit  forced;
    m_ho = 0;
    if (m_owner < 0) begin
      w = find_winner(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_hold = 0; m_ho = 1;
      end
    end else begin
      forced = HOLD_EN && (m_hold == MAX_HOLD - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
      if (!r[m_owner] || forced) begin
        m_ptr = (m_owner + 1) % 4;
        w = find_winner(r, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_hold = 0; m_ho = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endtask

  // Called just after a rising edge: apply r and predict the next edge.
  task automatic cycle(input logic [3:0] r);
    exp_t e;
    @(posedge clk);
    #1;
    req = r;
    model_step(r);
    e.cyc   = edge_cnt + 1;
    e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = 2'(m_last);
    e.valid = (m_owner >= 0);
    e.ho    = (m_ho != 0);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, then next request.
  task automatic reset_then(input logic [3:0] r);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_idx", gnt_idx, 2'b00);
    check("rst_valid", gnt_valid, 1'b0);
    check("rst_handover", handover, 1'b0);
    exp_q.delete();
    model_reset();
    #2;
    rst_n = 1'b1;
    req = r;
    begin
      exp_t e;
      model_step(r);
      e.cyc   = edge_cnt + 1;
      e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.idx   = 2'(m_last);
      e.valid = (m_owner >= 0);
      e.ho    = (m_ho != 0);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: on every falling edge compare the outputs of the last edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        if (exp_q[0].cyc < edge_cnt) begin
          e = exp_q.pop_front();
          check("stale_expectation", edge_cnt, e.cyc);
        end else if (exp_q[0].cyc == edge_cnt) begin
          e = exp_q.pop_front();
          check("gnt", gnt, e.gnt);
          check("gnt_idx", gnt_idx, e.idx);
          check("gnt_valid", gnt_valid, e.valid);
          check("handover", handover, e.ho);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [3:0] r;
    #1 rst_n = 1'b0;
    req = 4'b1111;
    #2;
    check("init_gnt", gnt, 4'b0000);
    check("init_valid", gnt_valid, 1'b0);
    @(posedge clk);
    #1;
    check("held_rst_gnt", gnt, 4'b0000);
    check("held_rst_idx", gnt_idx, 2'b00);
    check("held_rst_handover", handover, 1'b0);
    rst_n = 1'b1;
    req = 4'b0000;
    model_reset();

    // Single request, held, then released.
    repeat (6) cycle(4'b0100);
    repeat (2) cycle(4'b0000);

    // Full contention with owners dropping after two grant cycles.
    reset_then(4'b1111);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111);
      r = 4'b1111 & ~(4'b0001 << m_owner);
      cycle(r);
    end
    cycle(4'b0000);

    // Pointer rotation: after agent 2 releases, agent 0 wins over agent 2.
    reset_then(4'b0000);
    repeat (2) cycle(4'b0100);
    cycle(4'b0000);
    repeat (2) cycle(4'b0101);
    cycle(4'b0000);

    // Constant two-way contention (exercises the hold limit when built in).
    reset_then(4'b0011);
    repeat (14) cycle(4'b0011);
    cycle(4'b0000);

    // Reset while agent 3 owns the grant; agent 0 must win afterwards.
    reset_then(4'b1000);
    repeat (3) cycle(4'b1000);
    reset_then(4'b1001);
    repeat (3) cycle(4'b1001);

    // Random traffic with occasional asynchronous resets.
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        r = 4'($urandom_range(0, 15));
        reset_then(r);
      end else begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        if (m_owner >= 0 && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
        cycle(r);
      end
    end
    cycle(4'b0000);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
